// File: rtl/vga_timing_controller.sv
// VGA raster timing: free-running h/v counters, 1-based pixel coordinates for the
// image generator, and registered RGB/sync/active/frame_tick outputs aligned to one clock.
module vga_timing_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        active,
    output logic        frame_tick
);

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        active_q, active_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        tick_q, tick_d;
    logic        vis;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end

        vis = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        x   = vis ? h_cnt_q + 12'd1 : 12'd0;
        y   = vis ? v_cnt_q + 12'd1 : 12'd0;

        // Colour is sampled in the same cycle x/y are presented, so it lines up with active.
        rgb_d    = vis ? color : 3'b000;
        active_d = vis;
        hs_d     = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
        vs_d     = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
        tick_d   = (h_cnt_q == H_ACT - 12'd1) && (v_cnt_q == V_ACT - 12'd1);
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q  <= 12'd0;
            v_cnt_q  <= 12'd0;
            rgb_q    <= 3'b000;
            active_q <= 1'b0;
            hs_q     <= !SYNC_ACTIVE;
            vs_q     <= !SYNC_ACTIVE;
            tick_q   <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            rgb_q    <= rgb_d;
            active_q <= active_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            tick_q   <= tick_d;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign active     = active_q;
    assign VGA_HS     = hs_q;
    assign VGA_VS     = vs_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: a full-size instance checks line timing, a shrunken-raster
// instance (15x8 clocks/lines) checks vertical timing, wrap, frame_tick and mid-frame reset.
module tb_vga_timing_controller;

    logic        CLOCK_25 = 1'b0;
    logic        RESET_N;
    logic [2:0]  color;

    logic [11:0] d_x, d_y, s_x, s_y;
    logic        d_r, d_g, d_b, d_hs, d_vs, d_act, d_tick;
    logic        s_r, s_g, s_b, s_hs, s_vs, s_act, s_tick;

    int n_chk  = 0;
    int n_fail = 0;

    always #20 CLOCK_25 = ~CLOCK_25;

    vga_timing_controller u_full (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .color(color),
        .x(d_x), .y(d_y), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .active(d_act), .frame_tick(d_tick)
    );

    // Small raster: H 8+2+3+2=15, V 4+1+2+1=8, frame = 120 clocks
    vga_timing_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) u_small (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .color(color),
        .x(s_x), .y(s_y), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .active(s_act), .frame_tick(s_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int tick_in_rst;
        int act_cnt, act_first, act_last, rgb_err, x_err;
        int hs_cnt, hs_first, hs_last;
        int tk_cnt, tk_first, tk_last;
        int vs_cnt, vs_first;
        int act_800, act_801;
        int found;
        int h;

        RESET_N = 1'b0;
        color   = 3'b111;
        tick_in_rst = 0;
        repeat (5) begin
            @(posedge CLOCK_25); #1;
            if (d_tick || s_tick) tick_in_rst++;
        end
        chk("rst_rgb",    {29'd0, d_r, d_g, d_b}, 32'd0);
        chk("rst_active", {31'd0, d_act}, 32'd0);
        chk("rst_hs",     {31'd0, d_hs}, 32'd1);
        chk("rst_vs",     {31'd0, d_vs}, 32'd1);
        chk("rst_tick",   tick_in_rst, 0);
        chk("rst_x",      {20'd0, d_x}, 32'd1);
        chk("rst_y",      {20'd0, d_y}, 32'd1);

        @(negedge CLOCK_25);
        RESET_N = 1'b1;
        color   = 3'b101;

        act_cnt = 0; act_first = -1; act_last = -1; rgb_err = 0; x_err = 0;
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        tk_cnt = 0; tk_first = -1; tk_last = -1;
        vs_cnt = 0; vs_first = -1;
        act_800 = -1; act_801 = -1;

        // t = number of posedges since release; sampled 1 time unit after the edge
        for (int t = 1; t <= 801; t++) begin
            @(posedge CLOCK_25); #1;
            if (t == 1) chk("x_after_release", {20'd0, d_x}, 32'd2);
            if (t <= 800) begin
                h = t % 800;
                if ({20'd0, d_x} != ((h < 640) ? h + 1 : 0)) x_err++;
                if (d_act) begin
                    act_cnt++;
                    if (act_first < 0) act_first = t;
                    act_last = t;
                end
                if ({d_r, d_g, d_b} != (d_act ? 3'b101 : 3'b000)) rgb_err++;
                if (!d_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = t;
                    hs_last = t;
                end
            end
            if (t == 800) act_800 = d_act;
            if (t == 801) act_801 = d_act;
            if (t <= 120 && !s_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = t;
            end
            if (s_tick) begin
                tk_cnt++;
                if (tk_first < 0) tk_first = t;
                tk_last = t;
            end
            if (t == 45)  chk("s_y_last_row",  {20'd0, s_y}, 32'd4);
            if (t == 52)  chk("s_x_last_col",  {20'd0, s_x}, 32'd8);
            if (t == 60)  chk("s_y_vblank",    {20'd0, s_y}, 32'd0);
            if (t == 119) chk("s_y_before_wrap", {20'd0, s_y}, 32'd0);
            if (t == 120) chk("s_xy_wrap", {8'd0, s_x, s_y}, {8'd0, 12'd1, 12'd1});
        end

        chk("line_active_cnt",   act_cnt, 640);
        chk("line_active_first", act_first, 1);
        chk("line_active_last",  act_last, 640);
        chk("line_rgb_err",      rgb_err, 0);
        chk("line_x_err",        x_err, 0);
        chk("line_period_end",   act_800, 0);
        chk("line_period_next",  act_801, 1);
        chk("hs_low_cnt",        hs_cnt, 96);
        chk("hs_fall",           hs_first, 657);
        chk("hs_last_low",       hs_last, 752);
        chk("full_vs_idle",      {31'd0, d_vs}, 32'd1);
        chk("s_vs_low_cnt",      vs_cnt, 30);
        chk("s_vs_fall",         vs_first, 76);
        chk("s_tick_first",      tk_first, 53);
        chk("s_tick_cnt",        tk_cnt, 7);
        chk("s_tick_last",       tk_last, 773);

        // Mid-frame reset between clock edges: outputs must drop without a clock
        chk("pre_rst_active", {31'd0, d_act}, 32'd1);
        chk("pre_rst_s_vs",   {31'd0, s_vs}, 32'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_active", {31'd0, d_act}, 32'd0);
        chk("async_rgb",    {29'd0, d_r, d_g, d_b}, 32'd0);
        chk("async_x",      {20'd0, d_x}, 32'd1);
        chk("async_s_vs",   {31'd0, s_vs}, 32'd1);
        chk("async_s_xy",   {8'd0, s_x, s_y}, {8'd0, 12'd1, 12'd1});

        repeat (3) @(posedge CLOCK_25);
        @(negedge CLOCK_25);
        RESET_N = 1'b1;
        found = -1;
        for (int t = 1; t <= 200; t++) begin
            @(posedge CLOCK_25); #1;
            if (s_tick) begin
                found = t;
                break;
            end
        end
        chk("tick_after_rst", found, 3 * 15 + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Display-side counterpart of the image generator: produces the VGA raster timing and the (x, y) pixel coordinates the image generator consumes.
- Takes the 3-bit colour back and drives the registered RGB and sync outputs to the VGA connector.
- Emits a once-per-frame tick so game logic can update positions during vertical blanking.
- Sits between the top level and the image generator in the 25 MHz pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of HSYNC/VSYNC while the sync pulse is asserted

Ports:
CLOCK_25  input  1  25 MHz pixel clock, the only clock
RESET_N  input  1  asynchronous active-low reset
color  input  3  pixel colour from the image generator for the current x/y, {R,G,B}
x  output  12  pixel column, 1..H_ACTIVE in active region, 0 in blanking
y  output  12  pixel row, 1..V_ACTIVE in active region, 0 in blanking
VGA_R  output  1  red
VGA_G  output  1  green
VGA_B  output  1  blue
VGA_HS  output  1  horizontal sync
VGA_VS  output  1  vertical sync
active  output  1  high while VGA_R/G/B carry visible pixel data
frame_tick  output  1  one-clock pulse per frame at start of vertical blanking

Behaviour:
Clock and reset:
- One clock, CLOCK_25; reset RESET_N is asynchronous, active-low.
- Reset: h_cnt=0, v_cnt=0, VGA_R/G/B=0, active=0, frame_tick=0, VGA_HS=VGA_VS=!SYNC_ACTIVE.
- Release takes effect on the first posedge after RESET_N rises. Reset mid-frame aborts the line immediately; the raster restarts at (0,0).

Counters:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments only when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1) gives (0,0).

Coordinate outputs (combinational from counters, zero latency):
- vis = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- x = vis ? h_cnt+1 : 0; y = vis ? v_cnt+1 : 0. Coordinates are 1-based, so the border pixels x==1, x==640, y==1, y==480 are visible. Width is 12 bits; no overflow is possible.

Registered outputs (1-clock latency, all mutually aligned):
- {VGA_R,VGA_G,VGA_B} <= vis ? color : 3'b000. Colour must be valid combinationally in the same cycle as x/y.
- active <= vis.
- VGA_HS <= (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC) ? SYNC_ACTIVE : !SYNC_ACTIVE.
- VGA_VS <= (V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC) ? SYNC_ACTIVE : !SYNC_ACTIVE. It is evaluated per clock, so its edges coincide with line starts (h_cnt=0).
- frame_tick <= (h_cnt==H_ACTIVE-1 && v_cnt==V_ACTIVE-1). This gives exactly 1 pulse per V_TOTAL*H_TOTAL clocks, right after the last visible pixel.

Other rules:
- No handshake. The colour source has no back-pressure; the controller free-runs.
- Blanking forces RGB=0 regardless of color.

Test Plan:
- Hold RESET_N=0 for 5 clocks with color=3'b111 -> RGB=000, active=0, VGA_HS=VGA_VS=1, frame_tick=0, x=1, y=1 (counters at 0,0); release -> x=2 after the first posedge.
- Run 1 line with color=3'b101 -> active high for exactly 640 consecutive clocks, RGB=101 throughout, 0 during blanking; x sequence 1..640 then 0 for 160 clocks; line period 800 clocks.
- Horizontal sync -> VGA_HS low exactly 96 clocks per line, falling 1 clock after h_cnt reaches 656, rising 1 clock after h_cnt reaches 752.
- Vertical sync and wrap -> VGA_VS low for exactly 2 lines (1600 clocks), starting with line 490; v_cnt and y return to 0/1 after 525 lines; frame period 420000 clocks.
- frame_tick -> exactly one 1-clock pulse per 420000 clocks, asserted the clock after x=640, y=480 is presented; never asserted during reset.
- Reset mid-frame (assert RESET_N=0 asynchronously at line 200, pixel 300, between clock edges) -> outputs reach reset values immediately without a clock edge; after release the next frame_tick arrives exactly 479*800+640 clocks later.
